// File: rtl/dtc_seq_engine.sv
// dtc_seq_engine: sequential decision-tree classifier walking a node table one node per cycle.
// Latency: D+1 cycles from the acceptance edge to out_valid, where D is the number of internal nodes visited.
// Backpressure: the result is held in DONE until out_ready; in_ready is high only in IDLE.
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   cfg_we/addr/wdata     - node-table write port, honoured only in IDLE
//   in_valid/in_ready/inp - feature vector input handshake
//   out_valid/out_ready   - result handshake; outp is the class, out_err flags an aborted walk
//   perf_dec/perf_err     - saturating decision/error counters (only with DTC_SEQ_PERF_EN defined)
//
// Node word layout: {leaf, feat[FW-1:0], right[NODE_AW-1:0], left[NODE_AW-1:0]}.
// A leaf returns left[CLS_W-1:0] as the class.
module dtc_seq_engine #(
    parameter int N_FEAT    = 12,
    parameter int CLS_W     = 3,
    parameter int NODE_AW   = 9,
    parameter int MAX_DEPTH = 16
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      cfg_we,
    input  logic [NODE_AW-1:0]                        cfg_addr,
    input  logic [1+$clog2(N_FEAT)+2*NODE_AW-1:0]     cfg_wdata,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [N_FEAT-1:0]                         inp,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [CLS_W-1:0]                          outp,
    output logic                                      out_err
`ifdef DTC_SEQ_PERF_EN
    ,
    output logic [31:0]                               perf_dec,
    output logic [31:0]                               perf_err
`endif
);

    localparam int FW     = $clog2(N_FEAT);
    localparam int NODE_W = 1 + FW + 2*NODE_AW;
    localparam int DW     = $clog2(MAX_DEPTH + 1);

    // Constants pre-sized so comparisons stay width-matched.
    localparam logic [FW:0]   N_FEAT_L = N_FEAT[FW:0];
    localparam logic [DW-1:0] MAX_D    = MAX_DEPTH[DW-1:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NODE_AW-1:0]   node_q, node_d;
    logic [DW-1:0]        depth_q, depth_d;
    logic [N_FEAT-1:0]    feat_q, feat_d;
    logic [CLS_W-1:0]     outp_q, outp_d;
    logic                 err_q, err_d;

    // Node table: deliberately not reset; software fills it before use.
    logic [NODE_W-1:0]    node_mem [2**NODE_AW];

    logic [NODE_W-1:0]    nd;
    logic                 nd_leaf;
    logic [FW-1:0]        nd_feat;
    logic [NODE_AW-1:0]   nd_right;
    logic [NODE_AW-1:0]   nd_left;
    logic                 feat_bad;
    logic                 feat_bit;

    always_ff @(posedge clk) begin
        if (cfg_we && state_q == IDLE) begin
            node_mem[cfg_addr] <= cfg_wdata;
        end
    end

    assign nd       = node_mem[node_q];
    assign nd_leaf  = nd[NODE_W-1];
    assign nd_feat  = nd[2*NODE_AW +: FW];
    assign nd_right = nd[NODE_AW +: NODE_AW];
    assign nd_left  = nd[0 +: NODE_AW];
    assign feat_bad = ({1'b0, nd_feat} >= N_FEAT_L);
    // The index is only meaningful when feat_bad is low; the abort path ignores it.
    assign feat_bit = feat_bad ? 1'b0 : feat_q[nd_feat];

    always_comb begin
        state_d = state_q;
        node_d  = node_q;
        depth_d = depth_q;
        feat_d  = feat_q;
        outp_d  = outp_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                // A simultaneous table write wins; the vector waits a cycle.
                if (in_valid && !cfg_we) begin
                    feat_d  = inp;
                    node_d  = '0;
                    depth_d = '0;
                    state_d = WALK;
                end
            end
            WALK: begin
                if (nd_leaf) begin
                    outp_d  = nd_left[CLS_W-1:0];
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (feat_bad || depth_q == MAX_D) begin
                    outp_d  = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    node_d  = feat_bit ? nd_right : nd_left;
                    depth_d = depth_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            node_q  <= '0;
            depth_q <= '0;
            feat_q  <= '0;
            outp_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            node_q  <= node_d;
            depth_q <= depth_d;
            feat_q  <= feat_d;
            outp_q  <= outp_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign outp      = outp_q;
    assign out_err   = err_q;

`ifdef DTC_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_dec <= '0;
            perf_err <= '0;
        end else if (out_valid && out_ready) begin
            if (perf_dec != 32'hFFFF_FFFF) begin
                perf_dec <= perf_dec + 32'd1;
            end
            if (err_q && perf_err != 32'hFFFF_FFFF) begin
                perf_err <= perf_err + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dtc_seq_engine.sv
// Directed-vector bench for dtc_seq_engine with hand-computed expected classes and latencies.
module tb_dtc_seq_engine;

    localparam int N_FEAT  = 12;
    localparam int CLS_W   = 3;
    localparam int NODE_AW = 9;
    localparam int NODE_W  = 1 + 4 + 2*NODE_AW;

    logic                 clk;
    logic                 rst_n;
    logic                 cfg_we;
    logic [NODE_AW-1:0]   cfg_addr;
    logic [NODE_W-1:0]    cfg_wdata;
    logic                 in_valid;
    logic                 in_ready;
    logic [N_FEAT-1:0]    inp;
    logic                 out_valid;
    logic                 out_ready;
    logic [CLS_W-1:0]     outp;
    logic                 out_err;
`ifdef DTC_SEQ_PERF_EN
    logic [31:0]          perf_dec;
    logic [31:0]          perf_err;
`endif

    int n_cmp;
    int n_bad;

    dtc_seq_engine #(
        .N_FEAT(N_FEAT), .CLS_W(CLS_W), .NODE_AW(NODE_AW), .MAX_DEPTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .in_valid(in_valid), .in_ready(in_ready), .inp(inp),
        .out_valid(out_valid), .out_ready(out_ready),
        .outp(outp), .out_err(out_err)
`ifdef DTC_SEQ_PERF_EN
        , .perf_dec(perf_dec), .perf_err(perf_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NODE_W-1:0] mk_node(input logic leaf, input logic [3:0] feat,
                                                  input logic [8:0] right, input logic [8:0] left);
        return {leaf, feat, right, left};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_node(input logic [NODE_AW-1:0] a, input logic [NODE_W-1:0] w);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = w;
        tick();
        cfg_we    = 1'b0;
    endtask

    // Accepts vec, scrambles inp afterwards, measures latency, checks result, then drains.
    task automatic run_decision(input string tag, input logic [N_FEAT-1:0] vec,
                                input logic [CLS_W-1:0] exp_cls, input logic exp_err, input int exp_lat);
        int lat;
        in_valid = 1'b1;
        inp      = vec;
        tick();
        in_valid = 1'b0;
        inp      = ~vec;
        lat      = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_cls"}, {29'd0, outp}, {29'd0, exp_cls});
        check_eq({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        in_valid  = 1'b0;
        inp       = '0;
        out_ready = 1'b0;
        #12;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_outp", {29'd0, outp}, 32'd0);
        check_eq("rst_out_err", {31'd0, out_err}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Leaf at root; left carries extra upper bits that must be truncated to the class width.
        write_node(9'd0, mk_node(1'b1, 4'd0, 9'd0, 9'h1FD));
        run_decision("leaf5", 12'hABC, 3'd5, 1'b0, 1);

        // One split on feature 3.
        write_node(9'd0, mk_node(1'b0, 4'd3, 9'd1, 9'd2));
        write_node(9'd1, mk_node(1'b1, 4'd0, 9'd0, 9'd7));
        write_node(9'd2, mk_node(1'b1, 4'd0, 9'd0, 9'd2));
        run_decision("split_r", 12'h008, 3'd7, 1'b0, 2);
        run_decision("split_l", 12'hFF7, 3'd2, 1'b0, 2);

        // Table write and vector in the same IDLE cycle: write lands, vector is not taken.
        cfg_we    = 1'b1;
        cfg_addr  = 9'd2;
        cfg_wdata = mk_node(1'b1, 4'd0, 9'd0, 9'd6);
        in_valid  = 1'b1;
        inp       = 12'h000;
        tick();
        cfg_we    = 1'b0;
        in_valid  = 1'b0;
        check_eq("coll_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check_eq("coll_no_out", {31'd0, out_valid}, 32'd0);
        run_decision("coll_new", 12'h000, 3'd6, 1'b0, 2);

        // Hold the result with backpressure while trying to rewrite node 1.
        in_valid = 1'b1;
        inp      = 12'h008;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            cfg_we    = 1'b1;
            cfg_addr  = 9'd1;
            cfg_wdata = mk_node(1'b1, 4'd0, 9'd0, 9'd3);
            tick();
            check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
            check_eq("hold_outp", {29'd0, outp}, 32'd7);
            check_eq("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        run_decision("hold_table", 12'h008, 3'd7, 1'b0, 2);

        // Self-loop exhausts the depth budget: 16 internal visits then abort.
        write_node(9'd0, mk_node(1'b0, 4'd0, 9'd0, 9'd0));
        run_decision("loop", 12'h001, 3'd0, 1'b1, 17);

        // Out-of-range feature index aborts immediately.
        write_node(9'd0, mk_node(1'b0, 4'd13, 9'd1, 9'd2));
        run_decision("badfeat", 12'hFFF, 3'd0, 1'b1, 1);
        write_node(9'd0, mk_node(1'b0, 4'd12, 9'd1, 9'd2));
        run_decision("feat12", 12'hFFF, 3'd0, 1'b1, 1);

        // Reset mid-walk on the self-loop.
        write_node(9'd0, mk_node(1'b0, 4'd0, 9'd0, 9'd0));
        in_valid = 1'b1;
        inp      = 12'h001;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check_eq("walk_busy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_ready", {31'd0, in_ready}, 32'd1);
`ifdef DTC_SEQ_PERF_EN
        check_eq("perf_dec_rst", perf_dec, 32'd0);
        check_eq("perf_err_rst", perf_err, 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_valid", {31'd0, out_valid}, 32'd0);
        write_node(9'd0, mk_node(1'b0, 4'd3, 9'd1, 9'd2));
        run_decision("post_rst", 12'h008, 3'd7, 1'b0, 2);
        write_node(9'd0, mk_node(1'b0, 4'd14, 9'd1, 9'd2));
        run_decision("post_err", 12'h000, 3'd0, 1'b1, 1);
`ifdef DTC_SEQ_PERF_EN
        check_eq("perf_dec_cnt", perf_dec, 32'd2);
        check_eq("perf_err_cnt", perf_err, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
